// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scan controller: frame-synchronous shadow loading, 4-bit PWM
// brightness, per-digit blanking. Define SEG_LZ_BLANK_EN to add leading-zero blanking.
module seg_scan_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [3:0]            brightness,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int STEP  = REFRESH_DIV / 16;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SUB_W = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]    pre;
    logic [SUB_W-1:0]    sub;
    logic [3:0]          phase;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          level;
    logic                frame_start;
    logic                pending;
    logic                slot_end;
    logic                wrap;

    logic [4*DIGITS-1:0] shd_dig_p0;
    logic [DIGITS-1:0]   shd_dp_p0;
    logic [DIGITS-1:0]   shd_blank_p0;
    logic [4*DIGITS-1:0] dsp_dig_p1;
    logic [DIGITS-1:0]   dsp_dp_p1;
    logic [DIGITS-1:0]   dsp_blank_p1;

    logic [DIGITS-1:0]   blank_eff;
    logic [3:0]          lvl_eff;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                en;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign slot_end = (pre == PRE_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    // Scan timing: pre/sub/phase track the slot, idx selects the digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre         <= '0;
            sub         <= '0;
            phase       <= '0;
            idx         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (slot_end) begin
                pre   <= '0;
                sub   <= '0;
                phase <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
                if (sub == SUB_LAST) begin
                    sub   <= '0;
                    phase <= phase + 1'b1;
                end else begin
                    sub <= sub + 1'b1;
                end
            end
        end
    end

    // The level used at pre==0 must equal the one held for the rest of the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (pre == '0) begin
            level <= brightness;
        end
    end

    assign lvl_eff = (pre == '0) ? brightness : level;

    // Stage p0 -> p1: shadow capture, display update only at frame wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= 1'b0;
            shd_dig_p0   <= '0;
            shd_dp_p0    <= '0;
            shd_blank_p0 <= '0;
            dsp_dig_p1   <= '0;
            dsp_dp_p1    <= '0;
            dsp_blank_p1 <= '0;
        end else if (wrap) begin
            pending <= 1'b0;
            if (load) begin
                dsp_dig_p1   <= digits_in;
                dsp_dp_p1    <= dp_in;
                dsp_blank_p1 <= blank_mask;
            end else if (pending) begin
                dsp_dig_p1   <= shd_dig_p0;
                dsp_dp_p1    <= shd_dp_p0;
                dsp_blank_p1 <= shd_blank_p0;
            end
        end else if (load) begin
            pending      <= 1'b1;
            shd_dig_p0   <= digits_in;
            shd_dp_p0    <= dp_in;
            shd_blank_p0 <= blank_mask;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic [DIGITS-1:0] lz;
    logic              lead;

    always_comb begin
        lz   = '0;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead  = lead && (dsp_dig_p1[4*i +: 4] == 4'h0) && !dsp_dp_p1[i];
            lz[i] = lead;
        end
    end

    assign blank_eff = dsp_blank_p1 | lz;
`else
    assign blank_eff = dsp_blank_p1;
`endif

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = dsp_dig_p1[4*i +: 4];
                cur_dp    = dsp_dp_p1[i];
                cur_blank = blank_eff[i];
            end
        end
    end

    assign en = (phase < lvl_eff) && !cur_blank;

    // Stage p1 -> outputs: decoded and gated, all registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_start;
            an         <= en ? ~(DIGITS'(1) << idx) : '1;
            seg        <= en ? hex7(cur_nib) : 7'h7F;
            dp         <= en ? ~cur_dp : 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (DIGITS=4, REFRESH_DIV=16): directed and random loads checked
// cycle by cycle against a frame-level model of what the display should show.
module tb_seg_scan_mux;

    localparam int DIGITS = 4;
    localparam int RD     = 16;
    localparam int FRAME  = DIGITS * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  brightness = '0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(DIGITS), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .blank_mask(blank_mask), .brightness(brightness), .load(load),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    logic [6:0] seg_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // model state: {blank[3:0], dp[3:0], digits[15:0]} for what is shown and what waits
    int          c;
    logic [23:0] m_disp;
    logic [23:0] m_next;
    bit          m_has_next;
    logic [3:0]  m_lvl;
    int          n_assert = 0;
    int          n_fail = 0;
    int          an_low_cnt;
    int          fd_cnt;

    function automatic logic [3:0] dark_digits(input logic [23:0] v);
        logic [3:0] m;
        m = v[23:20];
`ifdef SEG_LZ_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            if (v[4*i +: 4] != 4'h0 || v[16+i]) break;
            m[i] = 1'b1;
        end
`endif
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    task automatic set_data(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bm);
        digits_in  = d;
        dp_in      = dpv;
        blank_mask = bm;
    endtask

    task automatic cyc(input bit ld);
        int         pre;
        int         id;
        bit         lit;
        logic [3:0] dark;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        load = ld;
        pre  = c % RD;
        id   = (c / RD) % DIGITS;
        if (pre == 0) m_lvl = brightness;
        dark  = dark_digits(m_disp);
        lit   = (pre < int'(m_lvl)) && !dark[id];
        e_an  = lit ? ~(4'b0001 << id) : 4'hF;
        e_seg = lit ? seg_tbl[m_disp[id*4 +: 4]] : 7'h7F;
        e_dp  = lit ? ~m_disp[16+id] : 1'b1;
        e_fd  = (c % FRAME == 0) && (c >= FRAME);
        // a new frame shows the most recent load made before (or on) its boundary
        if (c % FRAME == FRAME - 1) begin
            if (ld) m_disp = {blank_mask, dp_in, digits_in};
            else if (m_has_next) m_disp = m_next;
            m_has_next = 1'b0;
        end else if (ld) begin
            m_next     = {blank_mask, dp_in, digits_in};
            m_has_next = 1'b1;
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        if (an != 4'hF) an_low_cnt++;
        if (frame_done) fd_cnt++;
        c++;
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0);
    endtask

    task automatic run_to(input int pos);
        while (c % FRAME != pos) cyc(1'b0);
    endtask

    task automatic model_reset();
        c          = 0;
        m_disp     = '0;
        m_next     = '0;
        m_has_next = 1'b0;
        m_lvl      = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'h1);
        check({tag, "_fd"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        #9 rst_n = 1'b1;

        // basic scan of 1234 at full brightness
        brightness = 4'd15;
        set_data(16'h1234, 4'h0, 4'h0);
        cyc(1'b1);
        run_to(0);
        fd_cnt = 0;
        run(2 * FRAME);
        check("fd_count_2frames", 32'(fd_cnt), 32'd2);

        // quarter duty, then dark
        brightness = 4'd4;
        run_to(0);
        an_low_cnt = 0;
        run(FRAME);
        check("an_low_b4", 32'(an_low_cnt), 32'd16);
        brightness = 4'd0;
        run_to(0);
        an_low_cnt = 0;
        run(FRAME);
        check("an_low_b0", 32'(an_low_cnt), 32'd0);

        // last load before the wrap wins
        brightness = 4'd15;
        run_to(20);
        set_data(16'hAAAA, 4'h0, 4'h0);
        cyc(1'b1);
        run(10);
        set_data(16'hBBBB, 4'h5, 4'h0);
        cyc(1'b1);
        run_to(0);
        run(FRAME);

        // load on the wrap cycle itself
        run_to(FRAME - 1);
        set_data(16'hF00F, 4'hA, 4'h0);
        cyc(1'b1);
        run(FRAME - 1);

        // decode coverage and leading-zero cases
        set_data(16'h89AB, 4'h3, 4'h4);
        cyc(1'b1);
        run_to(0);
        run(FRAME);
        set_data(16'hCDEF, 4'h0, 4'h0);
        cyc(1'b1);
        run_to(0);
        run(FRAME);
        set_data(16'h5670, 4'h0, 4'h0);
        cyc(1'b1);
        run_to(0);
        run(FRAME);
        set_data(16'h0005, 4'h0, 4'h0);
        cyc(1'b1);
        run_to(0);
        run(FRAME);
        set_data(16'h0000, 4'h0, 4'h0);
        cyc(1'b1);
        run_to(0);
        run(FRAME);
        set_data(16'h0050, 4'h4, 4'h0);
        cyc(1'b1);
        run_to(0);
        run(FRAME);

        // random loads and brightness changes
        for (int i = 0; i < 12 * FRAME; i++) begin
            bit ld;
            ld = ($urandom % 16) == 0;
            if (ld) set_data(16'($urandom), 4'($urandom), 4'($urandom % 4 == 0 ? $urandom : 0));
            if ($urandom % 40 == 0) brightness = 4'($urandom);
            cyc(ld);
        end

        // asynchronous reset mid-slot
        brightness = 4'd15;
        run_to(37);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        brightness = 4'd0;
        #2 rst_n = 1'b1;
        run(FRAME + 5);
        brightness = 4'd9;
        set_data(16'h3C7E, 4'h9, 4'h2);
        cyc(1'b1);
        run_to(0);
        run(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
